// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one combinational logic unit between two requesters.
// Optional per-requester grant counters are enabled with `define LOGIC_ARB_STATS_EN.
module logic_unit_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic [WIDTH-1:0] lu_a,
    output logic [WIDTH-1:0] lu_b,
    output logic [1:0]       lu_op,
    input  logic [WIDTH-1:0] lu_r,
    input  logic             lu_zero,
    input  logic             lu_negative,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_zero,
    output logic             rsp_negative,
    output logic             busy
`ifdef LOGIC_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic       rr_ptr;   // requester preferred when both are valid
    logic       id_p0;    // owner of the operation currently in the logic unit
    logic       grant0;
    logic       grant1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Grants are only offered in IDLE and never while reset is being applied.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset && state == IDLE) begin
            grant0 = req0_valid && (!req1_valid || !rr_ptr);
            grant1 = req1_valid && (!req0_valid || rr_ptr);
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= 1'b0;
            id_p0        <= 1'b0;
            lu_a         <= '0;
            lu_b         <= '0;
            lu_op        <= 2'b00;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_r        <= '0;
            rsp_zero     <= 1'b0;
            rsp_negative <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Grant: operands into the logic unit, pointer moves to the other requester
                    if (grant0 || grant1) begin
                        lu_a   <= grant1 ? req1_a  : req0_a;
                        lu_b   <= grant1 ? req1_b  : req0_b;
                        lu_op  <= grant1 ? req1_op : req0_op;
                        id_p0  <= grant1;
                        rr_ptr <= ~grant1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    // Logic unit has settled: capture result and flags
                    rsp_r        <= lu_r;
                    rsp_zero     <= lu_zero;
                    rsp_negative <= lu_negative;
                    rsp_id       <= id_p0;
                    rsp_valid    <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef LOGIC_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (grant0) grant_cnt0 <= sat_inc(grant_cnt0);
            if (grant1) grant_cnt1 <= sat_inc(grant_cnt1);
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter with a behavioural logic unit and arbitration model.
module tb_logic_unit_arbiter;
    localparam int W     = 32;
    localparam int CNT_W = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]   req0_op, req1_op;
    logic [W-1:0] lu_a, lu_b, lu_r;
    logic [1:0]   lu_op;
    logic         lu_zero, lu_negative;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_negative, busy;
    logic [W-1:0] rsp_r;
`ifdef LOGIC_ARB_STATS_EN
    logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

    always #5 clk = ~clk;

    logic_unit_arbiter #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .lu_a(lu_a), .lu_b(lu_b), .lu_op(lu_op), .lu_r(lu_r), .lu_zero(lu_zero), .lu_negative(lu_negative),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_r(rsp_r),
        .rsp_zero(rsp_zero), .rsp_negative(rsp_negative), .busy(busy)
`ifdef LOGIC_ARB_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // The shared logic unit itself
    always_comb begin
        lu_r        = ref_op(lu_a, lu_b, lu_op);
        lu_zero     = (lu_r == '0);
        lu_negative = lu_r[W-1];
    end

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    typedef struct packed {
        logic         id;
        logic [W-1:0] r;
        logic         z;
        logic         n;
    } exp_t;

    exp_t sbq[$];
    logic r0_s = 1'b0;
    logic r1_s = 1'b0;

    // Reference model: one operation outstanding, result visible two cycles after grant
    logic m_pend = 1'b0;
    int   m_t    = 0;
    logic m_last = 1'b1;
    int   m_c0   = 0;
    int   m_c1   = 0;

    always @(negedge clk) begin
        logic w0, w1;
        if (reset) begin
            m_pend = 1'b0; m_t = 0; m_last = 1'b1; m_c0 = 0; m_c1 = 0;
            sbq.delete();
            r0_s = 1'b0; r1_s = 1'b0;
        end else begin
            if (m_pend) m_t++;
            w0 = !m_pend && req0_valid && (!req1_valid || m_last);
            w1 = !m_pend && req1_valid && (!req0_valid || !m_last);
            chk("req0_ready", req0_ready, w0);
            chk("req1_ready", req1_ready, w1);
            chk("rsp_valid", rsp_valid, m_pend && m_t >= 2);
            chk("busy", busy, m_pend);
`ifdef LOGIC_ARB_STATS_EN
            chk("grant_cnt0", grant_cnt0, m_c0);
            chk("grant_cnt1", grant_cnt1, m_c1);
`endif
            r0_s = req0_ready;
            r1_s = req1_ready;
            if (m_pend && m_t >= 2 && rsp_ready) begin
                m_pend = 1'b0;
            end else if (w0 || w1) begin
                exp_t e;
                m_pend = 1'b1; m_t = 0; m_last = w1;
                e.id = w1;
                e.r  = w1 ? ref_op(req1_a, req1_b, req1_op) : ref_op(req0_a, req0_b, req0_op);
                e.z  = (e.r == '0);
                e.n  = e.r[W-1];
                sbq.push_back(e);
                if (w0 && m_c0 < (1 << CNT_W) - 1) m_c0++;
                if (w1 && m_c1 < (1 << CNT_W) - 1) m_c1++;
            end
        end
    end

    // Monitor: pops on each new response and checks it stays stable until taken
    logic         have = 1'b0;
    logic [W+2:0] held;

    always @(negedge clk) begin
        if (reset) begin
            have = 1'b0;
        end else if (rsp_valid) begin
            if (!have) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_r", rsp_r, e.r);
                    chk("rsp_zero", rsp_zero, e.z);
                    chk("rsp_negative", rsp_negative, e.n);
                end
                have = 1'b1;
                held = {rsp_id, rsp_zero, rsp_negative, rsp_r};
            end else begin
                chk("rsp_stable", {rsp_id, rsp_zero, rsp_negative, rsp_r} != held, 0);
            end
            if (rsp_ready) have = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        logic ok;
        ok = 1'b0;
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (id ? r1_s : r0_s) begin ok = 1'b1; break; end
        end
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        chk("grant_timeout", ok, 1'b1);
    endtask

    task automatic check_last(input logic id, input logic [W-1:0] r, input logic z, input logic n);
        for (int i = 0; i < 4; i++) cyc();
        chk("last_id", rsp_id, id);
        chk("last_r", rsp_r, r);
        chk("last_zero", rsp_zero, z);
        chk("last_neg", rsp_negative, n);
    endtask

    task automatic check_reset_state();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", {req0_ready, req1_ready}, 0);
        chk("rst_rsp_r", rsp_r, 0);
        chk("rst_lu", {lu_a, lu_b, lu_op}, 0);
    endtask

    initial begin
        reset = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 2'b00;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 2'b00;
        repeat (3) cyc();
        reset = 1'b0;
        check_reset_state();
        chk("rst_flags", {rsp_id, rsp_zero, rsp_negative}, 0);
        cyc();

        send(1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 2'b00);
        check_last(1'b0, 32'h00F000F0, 1'b0, 1'b0);
        send(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11);
        check_last(1'b1, 32'h00000000, 1'b1, 1'b0);
        send(1'b1, 32'h80000000, 32'h00000000, 2'b10);
        check_last(1'b1, 32'h80000000, 1'b0, 1'b1);

        // Both requesters continuously valid
        req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_op = 2'($urandom);
        req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom; req1_op = 2'($urandom);
        for (int i = 0; i < 15; i++) begin
            cyc();
            if (r0_s) begin req0_a = $urandom; req0_b = $urandom; req0_op = 2'($urandom); end
            if (r1_s) begin req1_a = $urandom; req1_b = $urandom; req1_op = 2'($urandom); end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) cyc();

        // Consumer stalls while both requesters wait
        rsp_ready = 1'b0;
        send(1'b0, 32'h12345678, 32'h0F0F0F0F, 2'b01);
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (6) cyc();
        chk("stall_no_grant", {r0_s, r1_s}, 0);
        rsp_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) cyc();

        // Reset while an operation is in EXEC
        send(1'b1, 32'hDEADBEEF, 32'h0000FFFF, 2'b00);
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        check_reset_state();
        repeat (2) cyc();

        // Randomised traffic with back-pressure and withdrawn requests
        for (int i = 0; i < 600; i++) begin
            cyc();
            if (req0_valid && r0_s) req0_valid = 1'b0;
            else if (req0_valid && $urandom_range(15) == 0) req0_valid = 1'b0;
            else if (!req0_valid && $urandom_range(2) == 0) begin
                req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_op = 2'($urandom);
                if ($urandom_range(7) == 0) req0_b = req0_a;
            end
            if (req1_valid && r1_s) req1_valid = 1'b0;
            else if (req1_valid && $urandom_range(15) == 0) req1_valid = 1'b0;
            else if (!req1_valid && $urandom_range(2) == 0) begin
                req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom; req1_op = 2'($urandom);
                if ($urandom_range(7) == 0) req1_b = ~req1_a;
            end
            rsp_ready = ($urandom_range(3) != 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (6) cyc();
        chk("sb_drained", sbq.size(), 0);
        chk("end_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
